// File: rtl/iter_divider_pkg.sv
// Shared constants and FSM state type for the iterative divider.
package iter_divider_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned CNT_W     = 6;

   typedef enum logic [1:0] {
      DivIdle    = 2'd0,
      DivCollect = 2'd1,
      DivCalc    = 2'd2,
      DivDone    = 2'd3
   } div_state_e;

endpackage

// File: rtl/iter_divider_sign_fix.sv
// Operand magnitude extraction and result sign restoration for signed division.
module iter_divider_sign_fix
   import iter_divider_pkg::*;
#(
   parameter int unsigned WIDTH  = DIV_WIDTH,
   parameter bit          SIGNED = 1'b1
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic [WIDTH-1:0] quo_mag,
   input  logic [WIDTH-1:0] rem_mag,
   input  logic             neg_quo,
   input  logic             neg_rem,
   output logic [WIDTH-1:0] dividend_mag,
   output logic [WIDTH-1:0] divisor_mag,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   if (SIGNED) begin : g_signed
      // The most negative value maps to itself, which is its correct unsigned magnitude.
      assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
      assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
      assign quotient     = neg_quo ? -quo_mag : quo_mag;
      assign remainder    = neg_rem ? -rem_mag : rem_mag;
   end else begin : g_unsigned
      logic unused_neg;
      assign unused_neg   = neg_quo ^ neg_rem;
      assign dividend_mag = dividend;
      assign divisor_mag  = divisor;
      assign quotient     = quo_mag;
      assign remainder    = rem_mag;
   end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring radix-2 divider with independent dividend/divisor
// handshakes and a one-cycle {quotient, remainder} result strobe.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int unsigned WIDTH  = DIV_WIDTH,
   parameter bit          SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tvalid
);

   div_state_e state_q, state_d;

   logic [WIDTH-1:0]   dvd_buf_q, dvs_buf_q;
   logic               have_dvd_q, have_dvs_q;
   logic [WIDTH-1:0]   quo_q, rem_q, dvs_mag_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               neg_quo_q, neg_rem_q;
   logic [2*WIDTH-1:0] dout_q;

   logic               hs_dvd, hs_dvs;
   logic [WIDTH-1:0]   dvd_eff, dvs_eff, dvd_mag, dvs_mag;
   logic [WIDTH:0]     rem_shift, diff;
   logic [WIDTH-1:0]   rem_n, quo_n, quo_res, rem_res;
   logic               neg_quo_n, neg_rem_n;

   assign hs_dvd = s_axis_dividend_tvalid & s_axis_dividend_tready;
   assign hs_dvs = s_axis_divisor_tvalid & s_axis_divisor_tready;

   // An operand not yet buffered must be handshaking in the cycle we enter CALC.
   assign dvd_eff = have_dvd_q ? dvd_buf_q : s_axis_dividend_tdata;
   assign dvs_eff = have_dvs_q ? dvs_buf_q : s_axis_divisor_tdata;

   // Divide-by-zero keeps the all-ones quotient un-negated.
   assign neg_quo_n = SIGNED & (dvd_eff[WIDTH-1] ^ dvs_eff[WIDTH-1]) & (|dvs_eff);
   assign neg_rem_n = SIGNED & dvd_eff[WIDTH-1];

   assign rem_shift = {rem_q, quo_q[WIDTH-1]};
   assign diff      = rem_shift - {1'b0, dvs_mag_q};
   assign rem_n     = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quo_n     = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

   iter_divider_sign_fix #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_sign_fix (
      .dividend     (dvd_eff),
      .divisor      (dvs_eff),
      .quo_mag      (quo_n),
      .rem_mag      (rem_n),
      .neg_quo      (neg_quo_q),
      .neg_rem      (neg_rem_q),
      .dividend_mag (dvd_mag),
      .divisor_mag  (dvs_mag),
      .quotient     (quo_res),
      .remainder    (rem_res)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= DivIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d                = state_q;
      s_axis_dividend_tready = 1'b0;
      s_axis_divisor_tready  = 1'b0;
      unique case (state_q)
         DivIdle: begin
            s_axis_dividend_tready = 1'b1;
            s_axis_divisor_tready  = 1'b1;
            if (hs_dvd && hs_dvs) begin
               state_d = DivCalc;
            end else if (hs_dvd || hs_dvs) begin
               state_d = DivCollect;
            end
         end
         DivCollect: begin
            s_axis_dividend_tready = ~have_dvd_q;
            s_axis_divisor_tready  = ~have_dvs_q;
            if ((have_dvd_q || hs_dvd) && (have_dvs_q || hs_dvs)) begin
               state_d = DivCalc;
            end
         end
         DivCalc: begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DivDone;
            end
         end
         DivDone: begin
            state_d = DivIdle;
         end
         default: state_d = DivIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         dvd_buf_q  <= '0;
         dvs_buf_q  <= '0;
         have_dvd_q <= 1'b0;
         have_dvs_q <= 1'b0;
         quo_q      <= '0;
         rem_q      <= '0;
         dvs_mag_q  <= '0;
         cnt_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dout_q     <= '0;
      end else begin
         if (state_q == DivIdle || state_q == DivCollect) begin
            if (hs_dvd) begin
               dvd_buf_q  <= s_axis_dividend_tdata;
               have_dvd_q <= 1'b1;
            end
            if (hs_dvs) begin
               dvs_buf_q  <= s_axis_divisor_tdata;
               have_dvs_q <= 1'b1;
            end
            if (state_d == DivCalc) begin
               have_dvd_q <= 1'b0;
               have_dvs_q <= 1'b0;
               quo_q      <= dvd_mag;
               rem_q      <= '0;
               dvs_mag_q  <= dvs_mag;
               cnt_q      <= '0;
               neg_quo_q  <= neg_quo_n;
               neg_rem_q  <= neg_rem_n;
            end
         end
         if (state_q == DivCalc) begin
            quo_q <= quo_n;
            rem_q <= rem_n;
            cnt_q <= cnt_q + CNT_W'(1);
            if (state_d == DivDone) begin
               dout_q <= {quo_res, rem_res};
            end
         end
      end
   end

   assign m_axis_dout_tdata  = dout_q;
   assign m_axis_dout_tvalid = (state_q == DivDone);

endmodule

// File: tb/tb_iter_divider.sv
// Directed checks of the iterative divider: unsigned and signed instances share stimulus.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] dvd_data, dvs_data;
   logic        dvd_valid, dvs_valid;
   logic        dvd_ready_u, dvs_ready_u, tvalid_u;
   logic        dvd_ready_s, dvs_ready_s, tvalid_s;
   logic [63:0] tdata_u, tdata_s;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   iter_divider #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
      .clk                    (clk),
      .resetn                 (resetn),
      .s_axis_dividend_tdata  (dvd_data),
      .s_axis_dividend_tvalid (dvd_valid),
      .s_axis_dividend_tready (dvd_ready_u),
      .s_axis_divisor_tdata   (dvs_data),
      .s_axis_divisor_tvalid  (dvs_valid),
      .s_axis_divisor_tready  (dvs_ready_u),
      .m_axis_dout_tdata      (tdata_u),
      .m_axis_dout_tvalid     (tvalid_u)
   );

   iter_divider #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
      .clk                    (clk),
      .resetn                 (resetn),
      .s_axis_dividend_tdata  (dvd_data),
      .s_axis_dividend_tvalid (dvd_valid),
      .s_axis_dividend_tready (dvd_ready_s),
      .s_axis_divisor_tdata   (dvs_data),
      .s_axis_divisor_tvalid  (dvs_valid),
      .s_axis_divisor_tready  (dvs_ready_s),
      .m_axis_dout_tdata      (tdata_s),
      .m_axis_dout_tvalid     (tvalid_s)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Stimulus only: both operands valid in cycle 0, then observe cycles 1..45.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                         output int pulses, output logic [63:0] res_u,
                         output logic [63:0] res_s);
      logic got_s;
      lat = -1;
      pulses = 0;
      res_u = '0;
      res_s = '0;
      got_s = 1'b0;
      dvd_data = a;
      dvs_data = b;
      dvd_valid = 1'b1;
      dvs_valid = 1'b1;
      next_cycle();
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         if (tvalid_u) begin
            pulses++;
            if (lat < 0) begin
               lat = c;
               res_u = tdata_u;
            end
         end
         if (tvalid_s && !got_s) begin
            got_s = 1'b1;
            res_s = tdata_s;
         end
         next_cycle();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
      dvd_data = '0;
      dvs_data = '0;
      next_cycle();
      next_cycle();
      resetn = 1'b1;
      total_cnt++;
      if ({dvd_ready_u, dvs_ready_u, tvalid_u} !== 3'b110) begin
         $display("FAIL reset_u_ctrl: got %b want 110", {dvd_ready_u, dvs_ready_u, tvalid_u});
      end else pass_cnt++;
      total_cnt++;
      if ({dvd_ready_s, dvs_ready_s, tvalid_s} !== 3'b110) begin
         $display("FAIL reset_s_ctrl: got %b want 110", {dvd_ready_s, dvs_ready_s, tvalid_s});
      end else pass_cnt++;
      total_cnt++;
      if ((tdata_u | tdata_s) !== 64'h0) begin
         $display("FAIL reset_tdata: got %h / %h want 0", tdata_u, tdata_s);
      end else pass_cnt++;
   endtask

   task automatic test_unsigned();
      int lat, pulses;
      logic [63:0] ru, rs;
      run_op(32'd100, 32'd7, lat, pulses, ru, rs);
      total_cnt++;
      if (lat !== 33) begin
         $display("FAIL u_latency: got %0d want 33", lat);
      end else pass_cnt++;
      total_cnt++;
      if (pulses !== 1) begin
         $display("FAIL u_pulses: got %0d want 1", pulses);
      end else pass_cnt++;
      total_cnt++;
      if (ru !== {32'd14, 32'd2}) begin
         $display("FAIL u_100_7: got %h want %h", ru, {32'd14, 32'd2});
      end else pass_cnt++;
      total_cnt++;
      if (rs !== {32'd14, 32'd2}) begin
         $display("FAIL s_100_7: got %h want %h", rs, {32'd14, 32'd2});
      end else pass_cnt++;
      total_cnt++;
      if (tdata_u !== {32'd14, 32'd2}) begin
         $display("FAIL u_hold: got %h want %h", tdata_u, {32'd14, 32'd2});
      end else pass_cnt++;
      run_op(32'hFFFF_FFFF, 32'd16, lat, pulses, ru, rs);
      total_cnt++;
      if (ru !== {32'h0FFF_FFFF, 32'd15}) begin
         $display("FAIL u_max_16: got %h want %h", ru, {32'h0FFF_FFFF, 32'd15});
      end else pass_cnt++;
      run_op(32'd5, 32'd0, lat, pulses, ru, rs);
      total_cnt++;
      if (ru !== {32'hFFFF_FFFF, 32'd5}) begin
         $display("FAIL u_div0: got %h want %h", ru, {32'hFFFF_FFFF, 32'd5});
      end else pass_cnt++;
      total_cnt++;
      if (lat !== 33) begin
         $display("FAIL u_div0_latency: got %0d want 33", lat);
      end else pass_cnt++;
      total_cnt++;
      if (rs !== {32'hFFFF_FFFF, 32'd5}) begin
         $display("FAIL s_div0_pos: got %h want %h", rs, {32'hFFFF_FFFF, 32'd5});
      end else pass_cnt++;
   endtask

   task automatic test_signed();
      int lat, pulses;
      logic [63:0] ru, rs;
      run_op(32'hFFFF_FFF9, 32'd2, lat, pulses, ru, rs);
      total_cnt++;
      if (rs !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
         $display("FAIL s_m7_2: got %h want %h", rs, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      end else pass_cnt++;
      run_op(32'd7, 32'hFFFF_FFFE, lat, pulses, ru, rs);
      total_cnt++;
      if (rs !== {32'hFFFF_FFFD, 32'd1}) begin
         $display("FAIL s_7_m2: got %h want %h", rs, {32'hFFFF_FFFD, 32'd1});
      end else pass_cnt++;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, pulses, ru, rs);
      total_cnt++;
      if (rs !== {32'h8000_0000, 32'd0}) begin
         $display("FAIL s_overflow: got %h want %h", rs, {32'h8000_0000, 32'd0});
      end else pass_cnt++;
      run_op(32'hFFFF_FFFB, 32'd0, lat, pulses, ru, rs);
      total_cnt++;
      if (rs !== {32'hFFFF_FFFF, 32'hFFFF_FFFB}) begin
         $display("FAIL s_div0_neg: got %h want %h", rs, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
      end else pass_cnt++;
      run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, pulses, ru, rs);
      total_cnt++;
      if (rs !== {32'd14, 32'hFFFF_FFFE}) begin
         $display("FAIL s_m100_m7: got %h want %h", rs, {32'd14, 32'hFFFF_FFFE});
      end else pass_cnt++;
   endtask

   task automatic test_skew();
      int lat = -1;
      logic [63:0] ru = '0;
      for (int c = 0; c <= 45; c++) begin
         dvd_valid = (c <= 3);
         dvd_data  = (c == 0) ? 32'd1000 : 32'hDEAD_0000;
         dvs_valid = (c == 3);
         dvs_data  = (c == 3) ? 32'd3 : 32'd99;
         if (c >= 1 && c <= 3) begin
            total_cnt++;
            if ({dvd_ready_u, dvs_ready_u} !== 2'b01) begin
               $display("FAIL skew_ready_c%0d: got %b want 01", c, {dvd_ready_u, dvs_ready_u});
            end else pass_cnt++;
         end
         if (c == 10) begin
            total_cnt++;
            if ({dvd_ready_u, dvs_ready_u} !== 2'b00) begin
               $display("FAIL calc_ready: got %b want 00", {dvd_ready_u, dvs_ready_u});
            end else pass_cnt++;
         end
         if (tvalid_u && lat < 0) begin
            lat = c;
            ru = tdata_u;
         end
         next_cycle();
      end
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
      total_cnt++;
      if (lat !== 36) begin
         $display("FAIL skew_latency: got %0d want 36", lat);
      end else pass_cnt++;
      total_cnt++;
      if (ru !== {32'd333, 32'd1}) begin
         $display("FAIL skew_result: got %h want %h", ru, {32'd333, 32'd1});
      end else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      dvd_data = 32'd50;
      dvs_data = 32'd7;
      dvd_valid = 1'b1;
      dvs_valid = 1'b1;
      next_cycle();
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
      for (int c = 1; c < 10; c++) next_cycle();
      resetn = 1'b0;
      next_cycle();
      resetn = 1'b1;
      total_cnt++;
      if ({dvd_ready_u, dvs_ready_u, dvd_ready_s, dvs_ready_s} !== 4'b1111) begin
         $display("FAIL midreset_ready: got %b want 1111",
                  {dvd_ready_u, dvs_ready_u, dvd_ready_s, dvs_ready_s});
      end else pass_cnt++;
      for (int c = 0; c < 40; c++) begin
         if (tvalid_u || tvalid_s) pulses++;
         next_cycle();
      end
      total_cnt++;
      if (pulses !== 0) begin
         $display("FAIL midreset_pulses: got %0d want 0", pulses);
      end else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat1 = -1;
      int lat2 = -1;
      int pulses = 0;
      logic [63:0] r1 = '0;
      logic [63:0] r2 = '0;
      for (int c = 0; c <= 75; c++) begin
         dvd_valid = (c <= 34);
         dvs_valid = (c <= 34);
         if (c == 0) begin
            dvd_data = 32'd100;
            dvs_data = 32'd7;
         end else if (c == 34) begin
            dvd_data = 32'd50;
            dvs_data = 32'd8;
         end else begin
            dvd_data = 32'h0000_1234;
            dvs_data = 32'd5;
         end
         if (tvalid_u) begin
            pulses++;
            if (lat1 < 0) begin
               lat1 = c;
               r1 = tdata_u;
            end else if (lat2 < 0) begin
               lat2 = c;
               r2 = tdata_u;
            end
         end
         next_cycle();
      end
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
      total_cnt++;
      if (lat1 !== 33 || r1 !== {32'd14, 32'd2}) begin
         $display("FAIL b2b_first: got c%0d %h want c33 %h", lat1, r1, {32'd14, 32'd2});
      end else pass_cnt++;
      total_cnt++;
      if (lat2 !== 67 || r2 !== {32'd6, 32'd2}) begin
         $display("FAIL b2b_second: got c%0d %h want c67 %h", lat2, r2, {32'd6, 32'd2});
      end else pass_cnt++;
      total_cnt++;
      if (pulses !== 2) begin
         $display("FAIL b2b_pulses: got %0d want 2", pulses);
      end else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_skew();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
